// File: rtl/diff_pkg.sv
// Shared types and constants for the diff sequencer.
// Holds the FSM state encoding, default operand/step widths and a helper
// that sizes the chunk position field (kept at least one bit wide).
package diff_pkg;

  localparam int DIFF_WIDTH = 32;
  localparam int DIFF_STEP  = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_SCAN = S_SCAN,
    ST_DONE = S_DONE
  } state_t;

  // Width of a bit index inside one chunk; a 1-bit chunk still gets a
  // 1-bit (always zero) position field so the port never collapses.
  function automatic int pos_width(input int step);
    return (step > 1) ? $clog2(step) : 1;
  endfunction

endpackage

// File: rtl/diff_chunk_enc.sv
// Lowest-set-bit encoder for one STEP-bit chunk of the difference vector.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: chunk (STEP bits in), hit (any bit set), pos (index of lowest set bit).
module diff_chunk_enc
  import diff_pkg::*;
#(
  parameter int STEP  = DIFF_STEP,
  parameter int POS_W = pos_width(DIFF_STEP)
) (
  input  logic [STEP-1:0]  chunk,
  output logic             hit,
  output logic [POS_W-1:0] pos
);

  // Walk from the top bit downwards so the last write is the lowest set bit.
  always_comb begin
    hit = |chunk;
    pos = '0;
    for (int i = STEP - 1; i >= 0; i--) begin
      if (chunk[i]) begin
        pos = POS_W'(i);
      end
    end
  end

endmodule

// File: rtl/diff_seq_ctrl.sv
// Multi-cycle "diff" sequencer: 1-based index of lowest differing bit of two operands, 0 if equal.
// Latency: hit in chunk k reported k+1 cycles after accept (1 cycle for equal operands).
// Backpressure: in_ready only in IDLE without flush; result held in DONE until res_ready.
// Ports: clk/rst_n (async active-low), flush (sync abort), in_valid/in_ready + inp1/inp2,
//        res_valid/res_ready + result, busy (high in SCAN or DONE).
module diff_seq_ctrl
  import diff_pkg::*;
#(
  parameter int WIDTH = DIFF_WIDTH,
  parameter int STEP  = DIFF_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int BASE_W = $clog2(WIDTH) + 1;
  localparam int POS_W  = pos_width(STEP);

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  shreg, shreg_nxt;
  logic [BASE_W-1:0] base, base_nxt;
  logic [WIDTH-1:0]  result_nxt;

  logic              chunk_hit;
  logic [POS_W-1:0]  chunk_pos;

  diff_chunk_enc #(
    .STEP  (STEP),
    .POS_W (POS_W)
  ) u_chunk_enc (
    .chunk (shreg[STEP-1:0]),
    .hit   (chunk_hit),
    .pos   (chunk_pos)
  );

  // flush blocks acceptance in the same cycle so an abort can never race a new operand.
  assign in_ready  = (state == ST_IDLE) && !flush;
  assign res_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      base   <= '0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      base   <= base_nxt;
      result <= result_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    base_nxt   = base;
    result_nxt = result;

    if (flush) begin
      // Abort discards any in-flight or pending result; result register keeps its value.
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            shreg_nxt = inp1 ^ inp2;
            base_nxt  = '0;
            state_nxt = ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (shreg == '0) begin
            // Only reachable on the first scan cycle: any remaining set bit is a hit.
            result_nxt = '0;
            state_nxt  = ST_DONE;
          end else if (chunk_hit) begin
            result_nxt = WIDTH'(base) + WIDTH'(chunk_pos) + WIDTH'(1);
            state_nxt  = ST_DONE;
          end else begin
            shreg_nxt = shreg >> STEP;
            base_nxt  = base + BASE_W'(STEP);
          end
        end

        ST_DONE: begin
          if (res_ready) begin
            state_nxt = ST_IDLE;
          end
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_diff_seq_ctrl.sv
// Scoreboard bench for diff_seq_ctrl: directed cases plus randomized traffic.
// Expected results come from a bit-by-bit reference scan; a negedge monitor
// pops expectations when res_valid appears and checks value, timing and handshakes.
module tb_diff_seq_ctrl;

  localparam int W    = 32;
  localparam int STEP = 4;

  typedef struct {
    logic [W-1:0] res;
    int           rise_cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] inp1;
  logic [W-1:0] inp2;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         busy;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   rand_mode = 0;
  exp_t q[$];

  diff_seq_ctrl #(.WIDTH(W), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp1      (inp1),
    .inp2      (inp2),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: 1-based index of the lowest differing bit, 0 if equal.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < W; i++) begin
      if (a[i] != b[i]) return W'(i + 1);
    end
    return '0;
  endfunction

  // Cycles from accept edge to res_valid: chunk index of the hit plus one.
  function automatic int ref_lat(input logic [W-1:0] r);
    if (r == 0) return 1;
    return (int'(r) - 1) / STEP + 1;
  endfunction

  // Offer one operand pair; push the expectation once acceptance is seen.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bit   ok;
    ok       = 0;
    inp1     = a;
    inp2     = b;
    in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.res      = ref_diff(a, b);
        e.rise_cyc = cyc + 1 + ref_lat(e.res);
        q.push_back(e);
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: in_ready never high for 0x%08h/0x%08h", a, b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inp1     = $urandom;
    inp2     = $urandom;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!busy && q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d", busy, q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Output monitor / scoreboard.
  exp_t cur;
  bit   active  = 0;
  bit   post_hs = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      active  = 0;
      post_hs = 0;
    end else begin
      chk("in_ready_vs_busy", W'(in_ready), W'(!busy && !flush));
      if (post_hs) begin
        chk("idle_after_handshake_busy", W'(busy), '0);
        chk("idle_after_handshake_valid", W'(res_valid), '0);
      end
      if (res_valid) begin
        chk("busy_in_done", W'(busy), W'(1));
        if (!active) begin
          if (q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL spurious_valid: result 0x%08h with no request pending (cycle %0d)", result, cyc);
          end else begin
            cur    = q.pop_front();
            active = 1;
            chk("result", result, cur.res);
            chk("latency_edge", W'(cyc), W'(cur.rise_cyc));
          end
        end else begin
          chk("result_stable", result, cur.res);
        end
      end else begin
        if (active) begin
          errors++;
          checks++;
          $display("FAIL valid_dropped: res_valid fell without handshake (cycle %0d)", cyc);
          active = 0;
        end
        if (busy) chk("busy_has_pending", W'(q.size() != 0), W'(1));
      end
      // Bookkeeping for the upcoming edge; flush outranks the handshake.
      post_hs = 0;
      if (flush) begin
        q.delete();
        active  = 0;
        post_hs = 1;
      end else if (res_valid && res_ready) begin
        active  = 0;
        post_hs = 1;
      end
    end
  end

  // Random backpressure and rare flushes during the randomized phase.
  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      res_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] a, b;

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    inp1      = '0;
    inp2      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_res_valid", W'(res_valid), '0);
    chk("reset_busy", W'(busy), '0);
    chk("reset_result", result, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic cases with the consumer always ready.
    send(32'h0000_0000, 32'h0000_0001);
    wait_idle();
    send(32'hFFFF_FFFF, 32'h7FFF_FFFF);
    wait_idle();
    send(32'h1234_5678, 32'h1234_5678);
    wait_idle();
    send(32'h0000_0100, 32'h0000_0000);
    wait_idle();

    // Held result: value and valid must stay put, in_valid pulses ignored.
    res_ready = 1'b0;
    send(32'h0000_0010, 32'h0000_0000);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      inp1     = $urandom;
      inp2     = $urandom;
      @(posedge clk);
      #1;
    end
    chk("held_valid", W'(res_valid), W'(1));
    chk("held_result", result, W'(5));
    in_valid  = 1'b0;
    res_ready = 1'b1;
    wait_idle();

    // Flush mid-scan at E4, then a fresh request accepted at E5.
    send(32'hFFFF_FFFF, 32'h7FFF_FFFF);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_idle_busy", W'(busy), '0);
    send(32'h0000_0000, 32'h0000_0008);
    wait_idle();

    // Asynchronous reset between edges during a scan.
    send(32'hFFFF_FFFF, 32'h7FFF_FFFF);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_res_valid", W'(res_valid), '0);
    chk("async_rst_busy", W'(busy), '0);
    chk("async_rst_result", result, '0);
    chk("async_rst_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(32'h0000_0000, 32'h8000_0000);
    wait_idle();

    // Randomized traffic with random backpressure and flushes.
    rand_mode = 1;
    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      if ($urandom_range(0, 4) == 0) b = a;
      else b = a ^ ($urandom << $urandom_range(0, 31));
      send(a, b);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rand_mode = 0;
    @(posedge clk);
    #2;
    flush     = 1'b0;
    res_ready = 1'b1;
    wait_idle();
    chk("drain_pending", W'(q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
